hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_fwd_unit_pkg.sv | 18 +
 rtl/hazard_shadow_pipe.sv | 36 +++
 rtl/hazard_fwd_unit.sv | 175 +++++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared CPU definitions used by the hazard/forwarding unit: register-address
// width, hazard FSM states and the EX operand forward selects.
package hazard_fwd_unit_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned FWD_W  = 2;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FREEZE  = 2'd2
    } hz_state_t;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Two-stage shadow of the destination info leaving EX (MEM, then WB), built as a
// pipeline register with a hold enable so a memory freeze keeps both stages.
module hazard_shadow_pipe #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_reg_write
);

    // WB never needs MemRead: a load in WB forwards like any other writer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
        end else if (!hold) begin
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            mem_mem_read  <= ex_mem_read;
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: load-use stall, branch flush, memory freeze, EX operand
// forwarding selects and a saturating stall/freeze cycle counter.
module hazard_fwd_unit #(
    parameter int unsigned REG_AW = hazard_fwd_unit_pkg::REG_AW,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_RegWrite,
    input  logic              i_ex_MemRead,
    input  logic              i_branch_taken,
    input  logic              i_mem_busy,
    output logic              o_stall_if_id,
    output logic              o_flush_if_id,
    output logic              o_flush_id_ex,
    output logic              o_freeze,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    import hazard_fwd_unit_pkg::hz_state_t;
    import hazard_fwd_unit_pkg::RUN;
    import hazard_fwd_unit_pkg::LDSTALL;
    import hazard_fwd_unit_pkg::FREEZE;
    import hazard_fwd_unit_pkg::FWD_W;
    import hazard_fwd_unit_pkg::FWD_RF;
    import hazard_fwd_unit_pkg::FWD_MEM;
    import hazard_fwd_unit_pkg::FWD_WB;

    hz_state_t         state_q;
    hz_state_t         state_d;
    logic              load_use;
    logic              id_advance;
    logic [REG_AW-1:0] ex_rs1_q;
    logic [REG_AW-1:0] ex_rs2_q;
    logic              ex_rs1_used_q;
    logic              ex_rs2_used_q;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic [CNT_W-1:0]  stall_cnt_q;

    // MEM forwards only ALU results; a load still in MEM has no data yet.
    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic              used,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_rw,
        input logic              m_mr,
        input logic [REG_AW-1:0] w_rd,
        input logic              w_rw
    );
        logic [FWD_W-1:0] sel;
        sel = FWD_RF;
        if (used && (rs != '0)) begin
            if (m_rw && !m_mr && (m_rd == rs)) begin
                sel = FWD_MEM;
            end else if (w_rw && (w_rd == rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        load_use = i_ex_MemRead && i_ex_RegWrite && (i_ex_rd != '0) &&
                   ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                    (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));
    end

    // Control decode; reset forces every control low regardless of the inputs.
    always_comb begin
        o_stall_if_id = 1'b0;
        o_flush_if_id = 1'b0;
        o_flush_id_ex = 1'b0;
        o_freeze      = 1'b0;
        if (!reset) begin
            o_freeze = 1'b0;
        end else if (i_mem_busy) begin
            o_freeze = 1'b1;
        end else if (i_branch_taken) begin
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
        end else if (load_use) begin
            o_stall_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
        end
    end

    assign id_advance = !(o_freeze || o_stall_if_id || o_flush_if_id || o_flush_id_ex);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (i_mem_busy) begin
                    state_d = FREEZE;
                end else if (load_use && !i_branch_taken) begin
                    state_d = LDSTALL;
                end
            end
            LDSTALL: state_d = i_mem_busy ? FREEZE : RUN;
            FREEZE:  state_d = i_mem_busy ? FREEZE : RUN;
            default: state_d = RUN;
        endcase
    end

    // Source registers of the instruction now in EX, tracked alongside ID/EX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
        end else if (o_flush_id_ex) begin
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
        end else if (id_advance) begin
            ex_rs1_q      <= i_id_rs1;
            ex_rs2_q      <= i_id_rs2;
            ex_rs1_used_q <= i_id_rs1_used;
            ex_rs2_used_q <= i_id_rs2_used;
        end
    end

    hazard_shadow_pipe #(
        .REG_AW (REG_AW)
    ) u_shadow (
        .clk           (clk),
        .rst_n         (reset),
        .hold          (o_freeze),
        .ex_rd         (i_ex_rd),
        .ex_reg_write  (i_ex_RegWrite),
        .ex_mem_read   (i_ex_MemRead),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write)
    );

    always_comb begin
        o_fwd_a = fwd_sel(ex_rs1_used_q, ex_rs1_q, mem_rd, mem_reg_write,
                          mem_mem_read, wb_rd, wb_reg_write);
        o_fwd_b = fwd_sel(ex_rs2_used_q, ex_rs2_q, mem_rd, mem_reg_write,
                          mem_mem_read, wb_rd, wb_reg_write);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if ((o_stall_if_id || o_freeze) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed pipeline scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_hazard_fwd_unit;

    localparam int unsigned AW      = 5;
    localparam int unsigned CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    localparam logic [3:0] CTL_NONE  = 4'b0000;
    localparam logic [3:0] CTL_FRZ   = 4'b0001;
    localparam logic [3:0] CTL_FLUSH = 4'b0110;
    localparam logic [3:0] CTL_STALL = 4'b1010;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_u1, id_u2, ex_rw, ex_mr, br, busy;
    logic          o_stall_if_id, o_flush_if_id, o_flush_id_ex, o_freeze;
    logic [1:0]    o_fwd_a, o_fwd_b;
    logic [CW-1:0] o_stall_cnt;
    logic [3:0]    act_ctl;

    // model state: EX sources, last two EX writers (0 = MEM, 1 = WB), counter, FSM
    logic [AW-1:0] m_rs1, m_rs2;
    logic          m_u1, m_u2;
    logic [AW-1:0] w_rd [2];
    logic          w_rw [2];
    logic          w_mr [2];
    int            m_cnt;
    hazard_fwd_unit_pkg::hz_state_t m_state;

    int n_cmp;
    int n_bad;

    always #5 clk = ~clk;

    assign act_ctl = {o_stall_if_id, o_flush_if_id, o_flush_id_ex, o_freeze};

    hazard_fwd_unit #(
        .REG_AW (AW),
        .CNT_W  (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_rs1_used  (id_u1),
        .i_id_rs2_used  (id_u2),
        .i_ex_rd        (ex_rd),
        .i_ex_RegWrite  (ex_rw),
        .i_ex_MemRead   (ex_mr),
        .i_branch_taken (br),
        .i_mem_busy     (busy),
        .o_stall_if_id  (o_stall_if_id),
        .o_flush_if_id  (o_flush_if_id),
        .o_flush_id_ex  (o_flush_id_ex),
        .o_freeze       (o_freeze),
        .o_fwd_a        (o_fwd_a),
        .o_fwd_b        (o_fwd_b),
        .o_stall_cnt    (o_stall_cnt)
    );

    function automatic logic m_load_use();
        return ex_mr && ex_rw && (ex_rd != '0) &&
               ((id_u1 && (id_rs1 == ex_rd)) || (id_u2 && (id_rs2 == ex_rd)));
    endfunction

    // {stall_if_id, flush_if_id, flush_id_ex, freeze}
    function automatic logic [3:0] m_ctl();
        if (!reset)       return CTL_NONE;
        if (busy)         return CTL_FRZ;
        if (br)           return CTL_FLUSH;
        if (m_load_use()) return CTL_STALL;
        return CTL_NONE;
    endfunction

    function automatic logic [1:0] m_fwd(input logic used, input logic [AW-1:0] rs);
        if (!used || (rs == '0))                             return 2'd0;
        if (w_rw[0] && !w_mr[0] && (w_rd[0] == rs))          return 2'd1;
        if (w_rw[1] && (w_rd[1] == rs))                      return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_rs1 = '0; m_rs2 = '0; m_u1 = 1'b0; m_u2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            w_rd[k] = '0; w_rw[k] = 1'b0; w_mr[k] = 1'b0;
        end
        m_cnt   = 0;
        m_state = hazard_fwd_unit_pkg::RUN;
    endtask

    // advance the model across one rising edge using the pre-edge inputs
    task automatic model_update();
        logic [3:0] ctl;
        if (!reset) begin
            model_reset();
        end else begin
            ctl = m_ctl();
            case (m_state)
                hazard_fwd_unit_pkg::RUN:
                    if (busy) m_state = hazard_fwd_unit_pkg::FREEZE;
                    else if (m_load_use() && !br) m_state = hazard_fwd_unit_pkg::LDSTALL;
                default:
                    m_state = busy ? hazard_fwd_unit_pkg::FREEZE : hazard_fwd_unit_pkg::RUN;
            endcase
            if (ctl[1]) begin
                m_u1 = 1'b0; m_u2 = 1'b0;
            end else if (ctl == CTL_NONE) begin
                m_rs1 = id_rs1; m_rs2 = id_rs2; m_u1 = id_u1; m_u2 = id_u2;
            end
            if (!ctl[0]) begin
                w_rd[1] = w_rd[0]; w_rw[1] = w_rw[0]; w_mr[1] = w_mr[0];
                w_rd[0] = ex_rd;   w_rw[0] = ex_rw;   w_mr[0] = ex_mr;
            end
            if ((ctl[3] || ctl[0]) && (m_cnt < CNT_MAX)) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("ctl",       32'(act_ctl),       32'(m_ctl()));
        chk("fwd_a",     32'(o_fwd_a),       32'(m_fwd(m_u1, m_rs1)));
        chk("fwd_b",     32'(o_fwd_b),       32'(m_fwd(m_u2, m_rs2)));
        chk("stall_cnt", 32'(o_stall_cnt),   32'(m_cnt));
        chk("fsm_state", 32'(dut.state_q),   32'(m_state));
    endtask

    // one cycle: model compare before the edge, model advance at the edge
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic [AW-1:0] rs1, input logic u1,
                          input logic [AW-1:0] rs2, input logic u2,
                          input logic [AW-1:0] rd, input logic rw, input logic mr,
                          input logic b, input logic bz);
        id_rs1 = rs1; id_u1 = u1; id_rs2 = rs2; id_u2 = u2;
        ex_rd = rd; ex_rw = rw; ex_mr = mr; br = b; busy = bz;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        model_reset();
        set_in(5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_ctl", 32'(act_ctl), 32'(CTL_NONE));
        chk("rst_fwd", 32'({o_fwd_a, o_fwd_b}), 32'd0);
        chk("rst_cnt", 32'(o_stall_cnt), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // load x6, then add reading x6 as rs2
        set_in(5'd3, 1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lu_ctl", 32'(act_ctl), 32'(CTL_STALL));
        tick();
        set_in(5'd3, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_bubble_ctl", 32'(act_ctl), 32'(CTL_NONE));
        chk("lu_cnt", 32'(o_stall_cnt), 32'd1);
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_fwd_b", 32'(o_fwd_b), 32'd2);
        chk("lu_fwd_a", 32'(o_fwd_a), 32'd0);
        tick();

        // back-to-back ALU ops on x5, then with one unrelated op between
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("b2b_fwd_a", 32'(o_fwd_a), 32'd1);
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("gap_fwd_a", 32'(o_fwd_a), 32'd2);
        tick();

        // load to x0 with an x0 consumer
        set_in(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("x0_ctl", 32'(act_ctl), 32'(CTL_NONE));
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("x0_fwd", 32'({o_fwd_a, o_fwd_b}), 32'd0);
        tick();

        // load-use coinciding with a taken branch
        set_in(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("br_lu_ctl", 32'(act_ctl), 32'(CTL_FLUSH));
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // memory busy for 3 cycles inside a load-use window
        set_in(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(5'd0, 1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
            chk("frz_ctl", 32'(act_ctl), 32'(CTL_FRZ));
            chk("frz_hold_fwd_a", 32'(o_fwd_a), 32'd1);
            tick();
        end
        set_in(5'd0, 1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("frz_then_stall", 32'(act_ctl), 32'(CTL_STALL));
        chk("frz_then_fwd_a", 32'(o_fwd_a), 32'd1);
        tick();
        set_in(5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("frz_cnt", 32'(o_stall_cnt), 32'd5);
        tick();

        // reset asserted in the middle of a freeze
        set_in(5'd0, 1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(5'd0, 1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("pre_rst_cnt", 32'(o_stall_cnt), 32'd6);
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_ctl", 32'(act_ctl), 32'(CTL_NONE));
        chk("async_rst_fwd", 32'({o_fwd_a, o_fwd_b}), 32'd0);
        chk("async_rst_cnt", 32'(o_stall_cnt), 32'd0);
        chk("async_rst_state", 32'(dut.state_q), 32'(hazard_fwd_unit_pkg::RUN));
        tick();
        reset = 1'b1;
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_cnt", 32'(o_stall_cnt), 32'd0);
        tick();

        // counter saturation
        for (int k = 0; k < 20; k++) begin
            set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cnt_sat", 32'(o_stall_cnt), 32'd15);
        tick();

        // randomized traffic with occasional reset pulses
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                model_reset();
            end else begin
                reset = 1'b1;
            end
            set_in(AW'($urandom_range(0, 7)), ($urandom_range(0, 99) < 75),
                   AW'($urandom_range(0, 7)), ($urandom_range(0, 99) < 75),
                   AW'($urandom_range(0, 7)), ($urandom_range(0, 99) < 70),
                   ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 10),
                   ($urandom_range(0, 99) < 12));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
